branch_cond_unit: RTL

Parametrised branch-condition evaluator for the KGP-RISC branch path. Compares a register operand against zero or a second operand, signed or unsigned, and resolves an 8-way condition code into a registered taken/not-taken result. Adds a sticky compare-flag register and a hardware loop counter (decrement-and-branch). Sits between register-file read and PC-select logic, behind a valid/ready handshake with one cycle of latency.

---
 rtl/branch_cond_unit_if.sv | 41 ++++
 rtl/branch_cond_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/branch_cond_unit_if.sv
// Request/response bundle for branch_cond_unit: request fields, result fields,
// loop-counter control and the architectural flag/counter observation outputs.
interface branch_cond_unit_if #(
    parameter int WIDTH  = 32,
    parameter int LOOP_W = 16,
    parameter int TAG_W  = 32
);
    // Handshake: a request transfers on a rising edge where in_valid & in_ready;
    // a result transfers on a rising edge where out_valid & out_ready. in_ready is
    // the only combinational output and depends solely on out_valid/out_ready.
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic              signed_mode;
    logic              use_b;
    logic              use_flags;
    logic              flag_we;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [TAG_W-1:0]  in_tag;
    logic              loop_ld;
    logic [LOOP_W-1:0] loop_val;
    logic              out_valid;
    logic              out_ready;
    logic              taken;
    logic [TAG_W-1:0]  out_tag;
    logic [2:0]        flags;
    logic [LOOP_W-1:0] loop_cnt;

    modport slave (
        input  in_valid, op, signed_mode, use_b, use_flags, flag_we,
        input  a, b, in_tag, loop_ld, loop_val, out_ready,
        output in_ready, out_valid, taken, out_tag, flags, loop_cnt
    );

    modport master (
        output in_valid, op, signed_mode, use_b, use_flags, flag_we,
        output a, b, in_tag, loop_ld, loop_val, out_ready,
        input  in_ready, out_valid, taken, out_tag, flags, loop_cnt
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Branch-condition evaluator: live or stored {gt,eq,lt} compare, 8-way condition
// decode with decrement-and-branch loop counter, one-deep registered result stage.
module branch_cond_unit #(
    parameter int WIDTH  = 32,
    parameter int LOOP_W = 16,
    parameter int TAG_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_cond_unit_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_GT    = 3'd0,
        OP_LT    = 3'd1,
        OP_EQ    = 3'd2,
        OP_NEVER = 3'd3,
        OP_NE    = 3'd4,
        OP_GE    = 3'd5,
        OP_LE    = 3'd6,
        OP_DJNZ  = 3'd7
    } cond_op_e;

    logic              r_out_valid;
    logic              r_taken;
    logic [TAG_W-1:0]  r_out_tag;
    logic [2:0]        r_flags;
    logic [LOOP_W-1:0] r_loop_cnt;

    logic              w_accept;
    logic [WIDTH-1:0]  w_rhs;
    logic [WIDTH:0]    w_a_ext;
    logic [WIDTH:0]    w_rhs_ext;
    logic              w_lt;
    logic              w_eq;
    logic              w_gt;
    logic [2:0]        w_live;
    logic [2:0]        w_src;
    logic              w_cnt_nz;
    logic [LOOP_W-1:0] w_cnt_dec;
    logic              w_djnz;
    logic              w_taken;
    cond_op_e          w_op;

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_op         = cond_op_e'(bus.op);

    // One extra bit turns both interpretations into a single signed compare:
    // the extension bit is the sign bit in signed mode and zero otherwise.
    assign w_rhs     = bus.use_b ? bus.b : '0;
    assign w_a_ext   = {bus.signed_mode & bus.a[WIDTH-1], bus.a};
    assign w_rhs_ext = {bus.signed_mode & w_rhs[WIDTH-1], w_rhs};
    assign w_lt      = $signed(w_a_ext) < $signed(w_rhs_ext);
    assign w_eq      = (bus.a == w_rhs);
    assign w_gt      = !w_lt && !w_eq;
    assign w_live    = {w_gt, w_eq, w_lt};

    assign w_src     = bus.use_flags ? r_flags : w_live;

    assign w_cnt_nz  = (r_loop_cnt != '0);
    assign w_cnt_dec = r_loop_cnt - LOOP_W'(1);
    assign w_djnz    = (w_op == OP_DJNZ);

    always_comb begin
        w_taken = 1'b0;
        case (w_op)
            OP_GT:    w_taken = w_src[2];
            OP_LT:    w_taken = w_src[0];
            OP_EQ:    w_taken = w_src[1];
            OP_NEVER: w_taken = 1'b0;
            OP_NE:    w_taken = !w_src[1];
            OP_GE:    w_taken = w_src[2] || w_src[1];
            OP_LE:    w_taken = w_src[0] || w_src[1];
            OP_DJNZ:  w_taken = w_cnt_nz && (w_cnt_dec != '0);
            default:  w_taken = 1'b0;
        endcase
    end

    // Result stage: a new accept overwrites the held result, which is only
    // possible when the consumer is draining it in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_taken     <= w_taken;
            r_out_tag   <= bus.in_tag;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= 3'b000;
        end else if (w_accept && bus.flag_we) begin
            r_flags <= w_live;
        end
    end

    // An explicit load takes priority over a decrement in the same cycle;
    // the counter saturates at zero instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_loop_cnt <= '0;
        end else if (bus.loop_ld) begin
            r_loop_cnt <= bus.loop_val;
        end else if (w_accept && w_djnz && w_cnt_nz) begin
            r_loop_cnt <= w_cnt_dec;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.taken     = r_taken;
    assign bus.out_tag   = r_out_tag;
    assign bus.flags     = r_flags;
    assign bus.loop_cnt  = r_loop_cnt;

endmodule
